dm_mult_responder: RTL and testbench

Responder end of the Start/Ack job handshake used by the top level: a synthesizable engine that owns the data-memory port, waits for the host to finish preloading operands while holding Start high, launches on Start's return low, then fetches two 16-bit big-endian operands from data memory. It computes their 32-bit unsigned product by sequential shift-add, writes the result back to data memory, and raises Ack. It sits beside the data memory in the top level and replaces a software multiply routine for the operand/result layout at addresses 1..8.

---
 rtl/dm_mult_responder_if.sv | 34 +++
 rtl/dm_mult_responder.sv | 186 ++++++++++++++++++
 tb/tb_dm_mult_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_mult_responder_if.sv
// dm_mult_responder_if
// Bundles the Start/Ack job handshake and the data-memory port that the
// multiply responder owns.
//   Start     : host request (high = arm/hold, falling low = launch)
//   Ack       : job complete, held until the next Start high
//   Busy      : engine is loading, multiplying or storing
//   DataAddr  : data-memory address
//   ReadEn    : read strobe
//   WriteEn   : write strobe (memory writes on the rising edge)
//   WriteData : byte to write
//   DataIn    : combinational read data for DataAddr
// Modports:
//   master : host/memory side (drives Start and DataIn)
//   slave  : responder side (drives handshake status and memory port)
interface dm_mult_responder_if;
  logic       Start;
  logic       Ack;
  logic       Busy;
  logic [7:0] DataAddr;
  logic       ReadEn;
  logic       WriteEn;
  logic [7:0] WriteData;
  logic [7:0] DataIn;

  modport master (
    output Start, DataIn,
    input  Ack, Busy, DataAddr, ReadEn, WriteEn, WriteData
  );

  modport slave (
    input  Start, DataIn,
    output Ack, Busy, DataAddr, ReadEn, WriteEn, WriteData
  );
endinterface

// File: rtl/dm_mult_responder.sv
// dm_mult_responder
// Responder end of the Start/Ack job handshake. Once the host releases
// Start, the engine reads two 16-bit big-endian operands from data memory,
// multiplies them by sequential shift-add (one multiplier bit per cycle),
// writes the 32-bit product back most significant byte first and raises Ack.
// Ports:
//   Clk   : clock, all state updates on the rising edge
//   Reset : synchronous, active-high; clears all state
//   bus   : handshake + data-memory port (slave modport)
// Parameters:
//   A_ADDR / B_ADDR : MSB address of operand A / B (LSB at +1)
//   R_ADDR          : MSB address of the 4-byte result
module dm_mult_responder #(
  parameter logic [7:0] A_ADDR = 8'd1,
  parameter logic [7:0] B_ADDR = 8'd3,
  parameter logic [7:0] R_ADDR = 8'd5
) (
  input  logic               Clk,
  input  logic               Reset,
  dm_mult_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOAD,
    S_MUL,
    S_STORE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] p_q, p_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;

  logic [3:0]  cnt_inc;
  logic [31:0] partial;

  assign cnt_inc = cnt_q + 4'd1;
  // Shifted copy of A for the current multiplier bit.
  assign partial = b_q[cnt_q] ? ({16'd0, a_q} << cnt_q) : 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    // Memory strobes/address default low so idle, armed, done and abort
    // cycles present a quiet bus.
    addr_d  = 8'd0;
    wdata_d = 8'd0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) state_d = S_ARMED;
      end

      S_ARMED: begin
        if (!bus.Start) begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
          addr_d  = A_ADDR;
          rd_d    = 1'b1;
        end
      end

      S_LOAD: begin
        if (bus.Start) begin
          state_d = S_ARMED;
        end else begin
          case (cnt_q[1:0])
            2'd0: a_d[15:8] = bus.DataIn;
            2'd1: a_d[7:0]  = bus.DataIn;
            2'd2: b_d[15:8] = bus.DataIn;
            default: b_d[7:0] = bus.DataIn;
          endcase
          if (cnt_q[1:0] == 2'd3) begin
            state_d = S_MUL;
            cnt_d   = 4'd0;
            p_d     = 32'd0;
          end else begin
            cnt_d = cnt_inc;
            rd_d  = 1'b1;
            case (cnt_inc[1:0])
              2'd1: addr_d = A_ADDR + 8'd1;
              2'd2: addr_d = B_ADDR;
              default: addr_d = B_ADDR + 8'd1;
            endcase
          end
        end
      end

      S_MUL: begin
        if (bus.Start) begin
          state_d = S_ARMED;
        end else begin
          p_d = p_q + partial;
          if (cnt_q == 4'd15) begin
            // Present the first result byte straight from the final sum so
            // the first write lands on the very next edge.
            state_d = S_STORE;
            cnt_d   = 4'd0;
            addr_d  = R_ADDR;
            wdata_d = p_d[31:24];
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_STORE: begin
        if (bus.Start) begin
          state_d = S_ARMED;
        end else if (cnt_q[1:0] == 2'd3) begin
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_inc;
          addr_d = R_ADDR + {4'd0, cnt_inc};
          wr_d   = 1'b1;
          case (cnt_inc[1:0])
            2'd1: wdata_d = p_q[23:16];
            2'd2: wdata_d = p_q[15:8];
            default: wdata_d = p_q[7:0];
          endcase
        end
      end

      S_DONE: begin
        if (bus.Start) state_d = S_ARMED;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_MUL) || (state_d == S_STORE);
    ack_d  = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      p_q     <= 32'd0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Ack       = ack_q;
  assign bus.Busy      = busy_q;
  assign bus.DataAddr  = addr_q;
  assign bus.ReadEn    = rd_q;
  assign bus.WriteEn   = wr_q;
  assign bus.WriteData = wdata_q;

endmodule

// File: tb/tb_dm_mult_responder.sv
// tb_dm_mult_responder
// Drives the responder with preloaded operands through a small behavioural
// data memory and compares results, latency and bus behaviour against a
// plain-arithmetic product model.
module tb_dm_mult_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dm_mult_responder_if bus();

  dm_mult_responder dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge.
  logic [7:0] dm [256] = '{default: 8'h00};
  logic       host_we   = 1'b0;
  logic [7:0] host_addr = 8'd0;
  logic [7:0] host_data = 8'd0;

  assign bus.DataIn = dm[bus.DataAddr];

  always @(posedge clk) begin
    if (bus.WriteEn) dm[bus.DataAddr] = bus.WriteData;
    else if (host_we) dm[host_addr] = host_data;
  end

  // Bus activity monitors.
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int ovl_cnt = 0;
  always @(negedge clk) begin
    if (bus.ReadEn) rd_cnt++;
    if (bus.WriteEn) wr_cnt++;
    if (bus.Ack && bus.Busy) ovl_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    host_we   = 1'b1;
    host_addr = addr;
    host_data = data;
    @(negedge clk);
    host_we   = 1'b0;
  endtask

  // Waits for Ack after E0 has just passed; returns cycles counted from E0.
  task automatic wait_ack(output int n);
    n = 0;
    while (!bus.Ack && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] exp;
    exp = 32'(a) * 32'(b);
    chk({tag, "_r0"}, 32'(dm[5]), 32'(exp[31:24]));
    chk({tag, "_r1"}, 32'(dm[6]), 32'(exp[23:16]));
    chk({tag, "_r2"}, 32'(dm[7]), 32'(exp[15:8]));
    chk({tag, "_r3"}, 32'(dm[8]), 32'(exp[7:0]));
  endtask

  // Full job: raise Start, preload operands while armed, launch, wait.
  task automatic run_job(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    bus.Start = 1'b1;
    poke(8'd1, a[15:8]);
    chk({tag, "_ack_drop"}, 32'(bus.Ack), 32'd0);
    poke(8'd2, a[7:0]);
    poke(8'd3, b[15:8]);
    poke(8'd4, b[7:0]);
    bus.Start = 1'b0;
    @(negedge clk);                       // E0 has passed
    chk({tag, "_busy_e0"}, 32'(bus.Busy), 32'd1);
    chk({tag, "_addr_e0"}, 32'(bus.DataAddr), 32'd1);
    wait_ack(n);
    chk({tag, "_latency"}, 32'(n), 32'd24);
    check_result(tag, a, b);
    $display("job %s a=%h b=%h result=%02h%02h%02h%02h cycles=%0d",
             tag, a, b, dm[5], dm[6], dm[7], dm[8], n);
  endtask

  initial begin
    int n;
    int wr_snap;
    int rd_snap;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] exp;

    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_ack",   32'(bus.Ack),       32'd0);
    chk("rst_busy",  32'(bus.Busy),      32'd0);
    chk("rst_rden",  32'(bus.ReadEn),    32'd0);
    chk("rst_wren",  32'(bus.WriteEn),   32'd0);
    chk("rst_addr",  32'(bus.DataAddr),  32'd0);
    chk("rst_wdata", 32'(bus.WriteData), 32'd0);

    // Start held low: nothing happens.
    repeat (20) @(negedge clk);
    chk("idle_rd",   32'(rd_cnt),   32'd0);
    chk("idle_wr",   32'(wr_cnt),   32'd0);
    chk("idle_busy", 32'(bus.Busy), 32'd0);

    run_job("base", 16'h03FF, 16'hFFFB);
    chk("dm9_untouched", 32'(dm[9]), 32'd0);
    run_job("max",  16'hFFFF, 16'hFFFF);
    run_job("zero", 16'h0000, 16'h1234);
    run_job("b2b",  16'h0002, 16'h0003);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_job($sformatf("rnd%0d", i), ra, rb);
    end

    // Abort in MUL: Start sampled high at E0+10.
    bus.Start = 1'b1;
    poke(8'd5, 8'hEE);
    poke(8'd6, 8'hEE);
    poke(8'd7, 8'hEE);
    poke(8'd8, 8'hEE);
    poke(8'd1, 8'h12);
    poke(8'd2, 8'h34);
    poke(8'd3, 8'h56);
    poke(8'd4, 8'h78);
    bus.Start = 1'b0;
    @(negedge clk);                       // E0
    repeat (9) @(negedge clk);            // E9
    wr_snap = wr_cnt;
    bus.Start = 1'b1;
    @(negedge clk);                       // E10 sampled Start high
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_ack",  32'(bus.Ack),  32'd0);
    repeat (20) @(negedge clk);
    chk("abort_nowr", 32'(wr_cnt - wr_snap), 32'd0);
    chk("abort_ack2", 32'(bus.Ack), 32'd0);
    chk("abort_dm5",  32'(dm[5]), 32'hEE);
    bus.Start = 1'b0;
    @(negedge clk);                       // E0 of relaunch
    wait_ack(n);
    chk("abort_relaunch_latency", 32'(n), 32'd24);
    check_result("abort", 16'h1234, 16'h5678);
    $display("job abort a=1234 b=5678 result=%02h%02h%02h%02h cycles=%0d",
             dm[5], dm[6], dm[7], dm[8], n);

    // Reset mid-STORE: reset sampled at E22.
    bus.Start = 1'b1;
    poke(8'd5, 8'hEE);
    poke(8'd6, 8'hEE);
    poke(8'd7, 8'hEE);
    poke(8'd8, 8'hEE);
    poke(8'd1, 8'hAB);
    poke(8'd2, 8'hCD);
    poke(8'd3, 8'h98);
    poke(8'd4, 8'h76);
    bus.Start = 1'b0;
    @(negedge clk);                       // E0
    repeat (21) @(negedge clk);           // E21
    rst = 1'b1;
    @(negedge clk);                       // E22
    rst = 1'b0;
    chk("mrst_busy",  32'(bus.Busy),      32'd0);
    chk("mrst_ack",   32'(bus.Ack),       32'd0);
    chk("mrst_wren",  32'(bus.WriteEn),   32'd0);
    chk("mrst_rden",  32'(bus.ReadEn),    32'd0);
    chk("mrst_addr",  32'(bus.DataAddr),  32'd0);
    chk("mrst_wdata", 32'(bus.WriteData), 32'd0);
    exp = 32'h0000ABCD * 32'h00009876;
    chk("mrst_dm5", 32'(dm[5]), 32'(exp[31:24]));
    chk("mrst_dm6", 32'(dm[6]), 32'(exp[23:16]));
    chk("mrst_dm7", 32'(dm[7]), 32'hEE);
    chk("mrst_dm8", 32'(dm[8]), 32'hEE);
    $display("job midreset a=abcd b=9876 partial=%02h%02h%02h%02h",
             dm[5], dm[6], dm[7], dm[8]);
    rd_snap = rd_cnt;
    repeat (5) @(negedge clk);
    chk("mrst_idle_rd", 32'(rd_cnt - rd_snap), 32'd0);
    run_job("after_rst", 16'hABCD, 16'h9876);

    chk("ack_busy_overlap", 32'(ovl_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
